mem_responder: RTL and testbench
================================

# mem_responder

Word-organised memory slave that services load/store/fetch requests issued by the multicycle control unit (`UC`/`state_machineUC`) and datapath. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the byte-masked access and returns the result over a second valid/ready handshake. It is the responding end of the FETCH and memory-access traffic that the control FSM initiates.

## Interface
**Parameters**
- `DATA_W`, 32: data word width; a multiple of 8.
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 256: number of words in the array.
- `LATENCY`, 2: number of wait cycles between accept and access; legal range 0..15.

**Ports**
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: the block can accept a request; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load/fetch.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input DATA_W: store data.
- `req_wstrb` input DATA_W/8: byte enables for a store; ignored for a load.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: the consumer takes the response.
- `resp_rdata` output DATA_W: load data; 0 for stores and errors.
- `resp_err` output 1: access fault.
- `busy` output 1: high in WAIT or RESP.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, capture we/addr/wdata/wstrb.
  - If LATENCY=0, do the access at this edge and go to RESP.
  - Otherwise load `cnt`=LATENCY and go to WAIT.
- **WAIT:**
  - Decrement `cnt` each edge.
  - At the edge where `cnt`==1, do the access and go to RESP.
  - Request inputs are ignored.
- **Access:**
  - The word index is `addr[ADDR_W-1:2]` (for DATA_W=32).
  - Fault if `addr[1:0]`≠0 or the index ≥ DEPTH.
  - Fault: no array write; `resp_rdata`=0, `resp_err`=1.
  - Store: write only the bytes with a set strobe; `resp_rdata`=0.
  - Load: `resp_rdata` = the array word.
  - A store with `wstrb`=0 is legal, changes nothing and gets an OK response.
- **RESP:**
  - `resp_valid`=1; `resp_rdata`/`resp_err` are held stable.
  - On `resp_valid`&&`resp_ready`, go to IDLE.
  - Stall without limit while `resp_ready`=0.
- **Reset:**
  - FSM=IDLE, `cnt`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0.
  - `req_ready`=1 while reset is asserted.
  - Array contents are not reset.
- **Reset mid-operation:** a store not yet accessed is never written; a pending response is dropped.

## Timing
- A request is accepted at edge E0; the access happens at edge E0+LATENCY (E0 itself if LATENCY=0).
- `resp_valid` is high in the cycle after the access edge.
- LATENCY=0 gives a response the cycle after accept.
- `req_ready` returns 1 in the cycle after the response handshake edge. There is no accept in the same cycle as the response handshake.
- Minimum spacing between accepts is LATENCY+2 cycles.
- A load returns the array value as of the access edge.
- `req_ready` and `busy` decode directly from the state register; no combinational path from any input to any output.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the default DATA_W/ADDR_W/DEPTH;
  - `STRB_W = DATA_W/8`.
- Sub-module `mem_array`: a DEPTH×DATA_W array with synchronous byte-masked write and registered read, enabled only at the access edge. The FSM, counter and fault check stay in `mem_responder`.

## Test plan
- **Reset mid-store:** LATENCY=2; store 0x11223344 @0x10; drop `reset` during WAIT. Expected: `resp_valid` goes to 0 at once. A later load @0x10 returns the prior contents.
- **Byte-masked store:** store 0xAABBCCDD @0x10 with `wstrb`=4'b1111. Then store 0x00000011 @0x10 with `wstrb`=4'b0001. Expected: a load @0x10 returns 0xAABBCC11 with `resp_err`=0.
- **Latency sweep:** LATENCY=0 and LATENCY=3. Expected: `resp_valid` rises 1 cycle after accept for LATENCY=0 and 4 cycles after accept for LATENCY=3; `req_ready`=0 until 1 cycle after the response handshake.
- **Response back-pressure:** hold `resp_ready`=0 for 5 cycles after a load. Expected: `resp_valid`/`resp_rdata` stay stable, and `req_ready` stays 0 even with `req_valid`=1.
- **Faults:**
  - Load @0x0002 gives `resp_err`=1, `resp_rdata`=0.
  - Store @0x400 (index 256 with DEPTH=256) gives `resp_err`=1; the array is unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and default geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 256;
  localparam int STRB_W     = DEF_DATA_W / 8;

endpackage

// File: rtl/mem_array.sv
// Word array with byte-masked synchronous write and registered read, both gated by en.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data only changes on an enabled load, so it stays stable while a response waits.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory slave: accept, wait LATENCY cycles, byte-masked access, hold response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_wstrb,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int STRB_N = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_N);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int HI_W   = ADDR_W - OFF_W;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t state, state_nxt;
  logic [3:0] cnt;

  logic               accept;
  logic               acc_fire;
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [STRB_N-1:0]  acc_wstrb;
  logic [HI_W-1:0]    acc_hi;
  logic               fault;

  logic               we_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;
  logic [STRB_N-1:0]  wstrb_p0;

  logic               load_ok_p1;
  logic               err_p1;
  logic [DATA_W-1:0]  arr_rdata;

  assign accept   = (state == IDLE) && req_valid;
  assign acc_fire = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));

  // Zero latency accesses straight from the request bus; otherwise from the captured copy.
  assign acc_we    = (LATENCY == 0) ? req_we    : we_p0;
  assign acc_addr  = (LATENCY == 0) ? req_addr  : addr_p0;
  assign acc_wdata = (LATENCY == 0) ? req_wdata : wdata_p0;
  assign acc_wstrb = (LATENCY == 0) ? req_wstrb : wstrb_p0;

  assign acc_hi = acc_addr[ADDR_W-1:OFF_W];
  assign fault  = (acc_addr[OFF_W-1:0] != '0) || (acc_hi >= HI_W'(DEPTH));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= LAT4;
      else if (state == WAIT)  cnt <= cnt - 4'd1;
    end
  end

  // p0: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      wstrb_p0 <= req_wstrb;
    end
  end

  // p1: access outcome, held through RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ok_p1 <= 1'b0;
      err_p1     <= 1'b0;
    end else if (acc_fire) begin
      load_ok_p1 <= !fault && !acc_we;
      err_p1     <= fault;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (acc_fire && !fault),
    .we    (acc_we),
    .idx   (acc_hi[IDX_W-1:0]),
    .wdata (acc_wdata),
    .wstrb (acc_wstrb),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = err_p1;
  assign resp_rdata = load_ok_p1 ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at LATENCY 2, 0 and 3 sharing one clock and reset.
module tb_mem_responder;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [NDUT-1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, busy;
  logic [NDUT-1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [NDUT-1:0][3:0]  req_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .DEPTH   (256),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wstrb  (req_wstrb[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .busy       (busy[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input int d);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("resp_dut", d, e.dut);
      check("resp_rdata", resp_rdata[d], e.rdata);
      check("resp_err", {31'd0, resp_err[d]}, {31'd0, e.err});
    end
  endtask

  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic exp_err, input int bp);
    int  n;
    bit  seen;
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_idle", {31'd0, req_ready[d]}, 32'd1);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_wstrb[d]  = strb;
    resp_ready[d] = (bp == 0);
    sb.push_back('{d, exp_rd, exp_err});
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    n = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (resp_valid[d]) seen = 1;
      else check("ready_low_wait", {31'd0, req_ready[d]}, 32'd0);
    end
    check("resp_latency", n, lat_of(d) + 1);
    if (bp > 0) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'h0;
      for (int i = 0; i < bp; i++) begin
        check("bp_valid", {31'd0, resp_valid[d]}, 32'd1);
        check("bp_rdata", resp_rdata[d], exp_rd);
        check("bp_ready_low", {31'd0, req_ready[d]}, 32'd0);
        @(negedge clk);
      end
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b1;
    end
    if (seen) sb_pop(d);
    @(posedge clk);
    #1;
    check("ready_after_hs", {31'd0, req_ready[d]}, 32'd1);
    check("valid_after_hs", {31'd0, resp_valid[d]}, 32'd0);
    check("busy_after_hs", {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = '1;
    #1;
    check("rst_req_ready", {29'd0, req_ready}, 32'h7);
    check("rst_resp_valid", {29'd0, resp_valid}, 32'h0);
    check("rst_busy", {29'd0, busy}, 32'h0);
    check("rst_resp_err", {29'd0, resp_err}, 32'h0);
    check("rst_rdata0", resp_rdata[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // byte-masked stores and loads on the LATENCY=2 instance
    do_req(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b1111, 32'h0, 1'b0, 0);
    do_req(0, 1'b1, 32'h10, 32'h00000011, 4'b0001, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hAABBCC11, 1'b0, 0);
    do_req(0, 1'b1, 32'h20, 32'h55667788, 4'b1111, 32'h0, 1'b0, 0);
    do_req(0, 1'b1, 32'h20, 32'hA1B2C3D4, 4'b1010, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hA166C388, 1'b0, 0);
    do_req(0, 1'b1, 32'h14, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 0);
    do_req(0, 1'b1, 32'h14, 32'h12345678, 4'b0000, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 32'h14, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 0);

    // faults: misaligned and out-of-range, neither may touch the array
    do_req(0, 1'b0, 32'h2, 32'h0, 4'b0000, 32'h0, 1'b1, 0);
    do_req(0, 1'b1, 32'h0, 32'h01020304, 4'b1111, 32'h0, 1'b0, 0);
    do_req(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 0);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h01020304, 1'b0, 0);
    do_req(0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hAABBCC11, 1'b0, 0);

    // back-pressure on a load
    do_req(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hA166C388, 1'b0, 5);

    // reset while a store waits: nothing is written
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h11223344;
    req_wstrb[0] = 4'b1111;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check("mid_store_busy", {31'd0, busy[0]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_store_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("mid_store_busy_rst", {31'd0, busy[0]}, 32'd0);
    check("mid_store_ready_rst", {31'd0, req_ready[0]}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hAABBCC11, 1'b0, 0);

    // reset while a response is pending: it is dropped
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 32'h14;
    resp_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pend_valid", {31'd0, resp_valid[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("pend_drop_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("pend_drop_rdata", resp_rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready[0] = 1'b1;
    do_req(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h01020304, 1'b0, 0);

    // latency sweep on the LATENCY=0 and LATENCY=3 instances
    do_req(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 0);
    do_req(1, 1'b0, 32'h8, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 0);
    do_req(1, 1'b0, 32'h3FF, 32'h0, 4'b0000, 32'h0, 1'b1, 0);
    do_req(2, 1'b1, 32'h3FC, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 0);
    do_req(2, 1'b1, 32'h3FC, 32'h00EE0000, 4'b0100, 32'h0, 1'b0, 0);
    do_req(2, 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h0BEEF00D, 1'b0, 3);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
